fetch_pc_unit: RTL and testbench

Instruction-fetch control stage sitting directly upstream of `program_counter`. Holds the 7-bit PC register and selects the next PC (increment, branch, jump, hold), which it presents on `next_pc_o` to `program_counter.next_in`. Owns the IF/ID pipeline register with stall/flush handling. Runs a halt state machine that drains the pipeline after a HALT opcode is fetched.

---
 rtl/fetch_defs_pkg.sv | 21 ++
 rtl/fetch_pc_unit_next_pc_mux.sv | 38 +++
 rtl/fetch_pc_unit.sv | 148 ++++++++++++++
 tb/tb_fetch_pc_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_defs_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, HALT opcode,
// drain length and halt-FSM state encodings.
package fetch_defs;

  localparam int ADDR_W       = 7;
  localparam int INSTR_W      = 32;
  localparam int DRAIN_CYCLES = 4;
  localparam logic [5:0] HALT_OPCODE = 6'b111111;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  // Returns the PC value that follows pc, wrapping at 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] pc_plus_one(input logic [ADDR_W-1:0] pc);
    return pc + {{(ADDR_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/fetch_pc_unit_next_pc_mux.sv
// Combinational next-PC priority select. A HALTED core ignores redirects;
// otherwise branch beats jump, and any redirect beats holds caused by
// drain, stall or a freshly fetched HALT.
module next_pc_mux
  import fetch_defs::*;
#(
  parameter int AW = 7
) (
  input  logic [AW-1:0] pc_i,
  input  fetch_state_e  state_i,
  input  logic          stall_i,
  input  logic          halt_fetch_i,
  input  logic          branch_taken_i,
  input  logic [AW-1:0] branch_target_i,
  input  logic          jump_i,
  input  logic [AW-1:0] jump_target_i,
  output logic [AW-1:0] next_pc_o
);

  // Priority chain selecting hold, redirect target or PC+1 (modulo 2^AW).
  always_comb begin
    next_pc_o = pc_i + {{(AW-1){1'b0}}, 1'b1};
    if (state_i == ST_HALTED) begin
      next_pc_o = pc_i;
    end else if (branch_taken_i) begin
      next_pc_o = branch_target_i;
    end else if (jump_i) begin
      next_pc_o = jump_target_i;
    end else if (state_i != ST_RUN) begin
      next_pc_o = pc_i;
    end else if (stall_i || halt_fetch_i) begin
      next_pc_o = pc_i;
    end else begin
      next_pc_o = pc_i + {{(AW-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch control: PC register, IF/ID pipeline register with
// stall/flush, and a RUN/DRAIN/HALTED machine that drains the pipe after a
// HALT opcode is fetched.
module fetch_pc_unit #(
  parameter int          ADDR_W       = 7,
  parameter int          INSTR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 7'd0,
  parameter logic [5:0]  HALT_OPCODE  = 6'b111111,
  parameter int          DRAIN_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               branch_taken_i,
  input  logic [ADDR_W-1:0]  branch_target_i,
  input  logic               jump_i,
  input  logic [ADDR_W-1:0]  jump_target_i,
  input  logic [INSTR_W-1:0] imem_instr_i,
  output logic [ADDR_W-1:0]  imem_addr_o,
  output logic [ADDR_W-1:0]  next_pc_o,
  output logic [INSTR_W-1:0] if_id_instr_o,
  output logic [ADDR_W-1:0]  if_id_pc1_o,
  output logic               if_id_valid_o,
  output logic               halted_o
);
  import fetch_defs::*;

  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  pc1_s;
  logic [ADDR_W-1:0]  next_pc_s;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  pc1_q;
  logic               valid_q;
  fetch_state_e       state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               redirect_s;
  logic               halt_fetch_s;
  logic               load_halt_s;

  assign pc1_s        = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
  // A HALTED core ignores redirects entirely.
  assign redirect_s   = (state_q != ST_HALTED) && (branch_taken_i || jump_i);
  assign halt_fetch_s = (imem_instr_i[INSTR_W-1 -: 6] == HALT_OPCODE);
  assign load_halt_s  = (state_q == ST_RUN) && halt_fetch_s && !stall_i &&
                        !redirect_s && !flush_i;

  next_pc_mux #(.AW(ADDR_W)) u_next_pc_mux (
    .pc_i            (pc_q),
    .state_i         (state_q),
    .stall_i         (stall_i),
    .halt_fetch_i    (halt_fetch_s),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .jump_i          (jump_i),
    .jump_target_i   (jump_target_i),
    .next_pc_o       (next_pc_s)
  );

  // PC register follows the selected next PC every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= next_pc_s;
    end
  end

  // IF/ID register: squash on redirect/flush, hold on stall, load in RUN, bubble otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= {INSTR_W{1'b0}};
      pc1_q   <= {ADDR_W{1'b0}};
      valid_q <= 1'b0;
    end else if (redirect_s || flush_i) begin
      instr_q <= {INSTR_W{1'b0}};
      valid_q <= 1'b0;
    end else if (stall_i) begin
      instr_q <= instr_q;
      pc1_q   <= pc1_q;
      valid_q <= valid_q;
    end else if (state_q == ST_RUN) begin
      instr_q <= imem_instr_i;
      pc1_q   <= pc1_s;
      valid_q <= 1'b1;
    end else begin
      instr_q <= {INSTR_W{1'b0}};
      valid_q <= 1'b0;
    end
  end

  // Halt FSM state and drain counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Halt FSM next state: enter DRAIN on a loaded HALT, leave on redirect or after the drain count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (load_halt_s) begin
          state_d = ST_DRAIN;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (redirect_s) begin
          // HALT was on a mispredicted path.
          state_d = ST_RUN;
          cnt_d   = {CNT_W{1'b0}};
        end else if (stall_i) begin
          cnt_d   = cnt_q;
        end else if (cnt_q == CNT_W'(DRAIN_CYCLES)) begin
          state_d = ST_HALTED;
        end else begin
          cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  assign imem_addr_o   = pc_q;
  assign next_pc_o     = next_pc_s;
  assign if_id_instr_o = instr_q;
  assign if_id_pc1_o   = pc1_q;
  assign if_id_valid_o = valid_q;
  assign halted_o      = (state_q == ST_HALTED);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed and randomized bench for fetch_pc_unit against a behavioural
// model of the fetch rules.
module tb_fetch_pc_unit;

  localparam int M_RUN = 0, M_DRAIN = 1, M_HALT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, flush = 1'b0, br = 1'b0, jp = 1'b0;
  logic [6:0]  bt = 7'd0, jt = 7'd0;
  logic [31:0] instr;
  logic [6:0]  imem_addr, next_pc, pc1;
  logic [31:0] id_instr;
  logic        id_valid, halted;

  logic [31:0] mem [128];
  assign instr = mem[imem_addr];

  fetch_pc_unit dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .flush_i(flush),
    .branch_taken_i(br), .branch_target_i(bt), .jump_i(jp), .jump_target_i(jt),
    .imem_instr_i(instr), .imem_addr_o(imem_addr), .next_pc_o(next_pc),
    .if_id_instr_o(id_instr), .if_id_pc1_o(pc1), .if_id_valid_o(id_valid),
    .halted_o(halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int          m_pc, m_mode, m_drain, m_valid, m_pc1;
  logic [31:0] m_instr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] op;
    op = 6'($urandom_range(0, 62));
    return {op, 26'($urandom)};
  endfunction

  function automatic int model_npc();
    bit hf;
    hf = (m_mode == M_RUN) && (mem[m_pc][31:26] == 6'h3f);
    if (m_mode == M_HALT) return m_pc;
    if (br) return int'(bt);
    if (jp) return int'(jt);
    if (m_mode != M_RUN) return m_pc;
    if (stall || hf) return m_pc;
    return (m_pc + 1) % 128;
  endfunction

  task automatic model_reset();
    m_pc = 0; m_mode = M_RUN; m_drain = 0; m_valid = 0; m_pc1 = 0; m_instr = 32'd0;
  endtask

  task automatic check_outputs(input bit chk_pc1);
    chk("pc", 32'(imem_addr), 32'(m_pc));
    chk("valid", 32'(id_valid), 32'(m_valid));
    chk("instr", id_instr, m_instr);
    if (chk_pc1 || m_valid == 1) chk("pc1", 32'(pc1), 32'(m_pc1));
    chk("halted", 32'(halted), 32'(m_mode == M_HALT));
  endtask

  // One clock: drive controls, check next_pc, advance model and DUT, check state.
  task automatic cyc(input logic s, input logic f, input logic b, input logic [6:0] btv,
                     input logic j, input logic [6:0] jtv);
    int  npc;
    bit  redir, hf;
    stall = s; flush = f; br = b; bt = btv; jp = j; jt = jtv;
    #1;
    npc = model_npc();
    chk("next_pc", 32'(next_pc), 32'(npc));
    redir = (m_mode != M_HALT) && (b || j);
    hf    = (m_mode == M_RUN) && (mem[m_pc][31:26] == 6'h3f);
    if (redir || f) begin
      m_valid = 0; m_instr = 32'd0;
    end else if (s) begin
      // IF/ID keeps its contents
    end else if (m_mode == M_RUN) begin
      m_instr = mem[m_pc]; m_pc1 = (m_pc + 1) % 128; m_valid = 1;
    end else begin
      m_valid = 0; m_instr = 32'd0;
    end
    if (m_mode == M_RUN) begin
      if (hf && !s && !redir && !f) begin m_mode = M_DRAIN; m_drain = 0; end
    end else if (m_mode == M_DRAIN) begin
      if (redir) m_mode = M_RUN;
      else if (!s) begin
        m_drain++;
        if (m_drain == 5) m_mode = M_HALT;
      end
    end
    m_pc = npc;
    @(posedge clk);
    #1;
    check_outputs(1'b0);
  endtask

  task automatic do_reset();
    stall = 1'b0; flush = 1'b0; br = 1'b0; jp = 1'b0;
    rst_n = 1'b0;
    #2;
    model_reset();
    check_outputs(1'b1);
    chk("rst_next_pc", 32'(next_pc), 32'(model_npc()));
    rst_n = 1'b1;
    #2;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = rand_instr();
    #6;
    do_reset();

    // Free-running sequential fetch
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 7'd0);
      chk("seq_addr", 32'(imem_addr), 32'(i + 1));
      chk("seq_pc1", 32'(pc1), 32'(i + 1));
    end
    chk("seq_valid", 32'(id_valid), 32'd1);

    // Wrap 127 -> 0
    cyc(1'b0, 1'b0, 1'b0, 7'd0, 1'b1, 7'd127);
    chk("wrap_pre", 32'(imem_addr), 32'd127);
    cyc(1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 7'd0);
    chk("wrap_pc", 32'(imem_addr), 32'd0);
    chk("wrap_pc1", 32'(pc1), 32'd0);

    // Stall twice at 10, then branch together with stall
    cyc(1'b0, 1'b0, 1'b0, 7'd0, 1'b1, 7'd10);
    cyc(1'b1, 1'b0, 1'b0, 7'd0, 1'b0, 7'd0);
    cyc(1'b1, 1'b0, 1'b0, 7'd0, 1'b0, 7'd0);
    chk("stall_hold", 32'(imem_addr), 32'd10);
    cyc(1'b1, 1'b0, 1'b1, 7'd40, 1'b0, 7'd0);
    chk("stall_br_pc", 32'(imem_addr), 32'd40);
    chk("stall_br_bubble", 32'(id_valid), 32'd0);

    // Branch beats jump
    cyc(1'b0, 1'b0, 1'b1, 7'd20, 1'b1, 7'd60);
    chk("br_over_jp", 32'(imem_addr), 32'd20);

    // HALT at 8, drain to HALTED, then ignore jump
    mem[8] = {6'h3f, 26'h0000123};
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 7'd0);
    cyc(1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 7'd0);
    chk("halt_load_pc", 32'(imem_addr), 32'd8);
    chk("halt_load_valid", 32'(id_valid), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 7'd0);
      chk("drain_halted", 32'(halted), 32'(i == 5));
      chk("drain_valid", 32'(id_valid), 32'd0);
    end
    cyc(1'b0, 1'b0, 1'b0, 7'd0, 1'b1, 7'd3);
    chk("halted_jump_ignored", 32'(imem_addr), 32'd8);
    chk("halted_stays", 32'(halted), 32'd1);

    // HALT on mispredicted path: branch in DRAIN returns to RUN
    do_reset();
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 7'd0);
    cyc(1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 7'd0);
    cyc(1'b0, 1'b0, 1'b1, 7'd30, 1'b0, 7'd0);
    chk("mispred_pc", 32'(imem_addr), 32'd30);
    chk("mispred_halted", 32'(halted), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 7'd0);
    chk("mispred_run", 32'(imem_addr), 32'd31);
    do_reset();
    chk("async_rst_pc", 32'(imem_addr), 32'd0);
    chk("async_rst_valid", 32'(id_valid), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 128; i++)
      mem[i] = ($urandom_range(0, 15) == 0) ? {6'h3f, 26'($urandom)} : rand_instr();
    for (int n = 0; n < 1500; n++) begin
      if ((m_mode == M_HALT && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        cyc(1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 11) == 0), 7'($urandom),
            1'($urandom_range(0, 11) == 0), 7'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
